// File: rtl/fetch_pkg.sv
// Shared constants and the instruction-queue entry layout for the fetch stage.
package fetch_pkg;
    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_sync_fifo.sv
// Circular-buffer FIFO with occupancy count; flush empties it in one cycle.
// Push and pop may coincide at any occupancy, leaving the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next pointers and count; flush overrides any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer/count state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; stale contents are never observed through an empty queue.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, credit-limited memory requests, in-order
// instruction queue to decode, and redirect with wrong-path response dropping.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     tag_cnt, q_cnt;
    logic [CW:0]       occupancy;
    logic [XLEN-1:0]   tag_pc;
    logic [2*XLEN-1:0] q_rdata;
    logic              tag_full, tag_empty, q_full, q_empty;
    logic              issue, drop_rsp, q_push, q_pop;
    fetch_entry_t      head;

    // Outstanding requests plus buffered instructions never exceed DEPTH,
    // so a returning response always finds room in the queue.
    assign occupancy      = {1'b0, tag_cnt} + {1'b0, q_cnt};
    assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign issue          = imem_req_valid && imem_req_ready;

    assign drop_rsp = imem_rsp_valid && (drop_cnt_q != '0);
    assign q_push   = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign q_pop    = if_valid && if_ready;

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .pop_i   (imem_rsp_valid),
        .flush_i (1'b0),
        .wdata_i (pc_q),
        .rdata_o (tag_pc),
        .count_o (tag_cnt),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect_valid),
        .wdata_i ({imem_rsp_data, tag_pc}),
        .rdata_o (q_rdata),
        .count_o (q_cnt),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Decode outputs are forced to zero whenever nothing valid is presented.
    assign head        = q_rdata;
    assign if_valid    = !q_empty;
    assign if_instr    = if_valid ? head.instr : NOP_INSTR;
    assign if_pc       = if_valid ? head.pc : '0;
    assign if_pc_plus4 = if_valid ? head.pc + XLEN'(4) : '0;

    // Next PC and drop count; a redirect counts every request still in flight
    // after this cycle, a response arriving now being dropped as well.
    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = tag_cnt - CW'(imem_rsp_valid);
        end else begin
            if (issue)    pc_d       = pc_q + XLEN'(4);
            if (drop_rsp) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    // PC and drop-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Protocol sanity: the credit scheme must keep both FIFOs in range.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(q_push && q_full && !q_pop));
            assert (!(issue && tag_full && !imem_rsp_valid));
            assert (!(imem_rsp_valid && tag_empty));
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory model with variable in-order latency,
// and a scoreboard of the expected sequential instruction stream.
module tb_fetch_stage;
    import fetch_pkg::*;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h3C5A_96E1;
    endfunction

    // Reference: after reset/redirect decode sees target, target+4, ... in order.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] exp_tail;

    task automatic extend();
        exp_t e;
        repeat (8) begin
            e.pc = exp_tail; e.instr = mdata(exp_tail);
            exp_q.push_back(e);
            exp_tail = exp_tail + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        exp_tail = pc;
        extend();
    endtask

    // Memory model: drives responses at negedge, samples requests at negedge+2.
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend[$];
    logic [31:0] issue_log[$];
    int cyc = 0, lat_min = 1, lat_max = 1, req_pct = 100;

    always @(negedge clk) begin
        pend_t p;
        cyc++;
        if (!rst_n) begin
            pend.delete(); issue_log.delete();
            imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_data = 32'h0;
        end else begin
            imem_req_ready = ($urandom_range(99) < req_pct);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1; imem_rsp_data = mdata(pend[0].addr);
            end else begin
                imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
            end
        end
        #2;
        if (rst_n) begin
            if (imem_rsp_valid) void'(pend.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                chk("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
                p.addr = imem_req_addr;
                p.due  = cyc + int'($urandom_range(lat_max, lat_min));
                if (pend.size() > 0 && p.due <= pend[pend.size()-1].due)
                    p.due = pend[pend.size()-1].due + 1;
                pend.push_back(p);
                issue_log.push_back(imem_req_addr);
                chk("credit", 32'(pend.size() <= DEPTH), 32'd1);
            end
        end
    end

    // Monitor: every decode handshake (outside reset and redirect cycles) pops the scoreboard.
    int n_acc = 0;
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] p4;
        #2;
        if (rst_n && if_valid && if_ready && !redirect_valid) begin
            if (exp_q.size() == 0) extend();
            e  = exp_q.pop_front();
            p4 = e.pc + 32'd4;
            chk("if_pc", if_pc, e.pc);
            chk("if_instr", if_instr, e.instr);
            chk("if_pc_plus4", if_pc_plus4, p4);
            n_acc++;
            if (exp_q.size() < 4) extend();
        end
    end

    int rdy_pct = 100;

    task automatic tick();
        @(negedge clk); #1;
        if_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Called at negedge+1 of cycle R; returns at negedge+2 of R+1.
    task automatic redirect(input logic [31:0] t);
        logic [31:0] tgt;
        tgt = {t[31:2], 2'b00};
        redirect_valid = 1'b1; redirect_pc = t;
        restart(tgt); issue_log.delete();
        #1;
        chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_pc", imem_req_addr, tgt);
        chk("redir_flushed", 32'(if_valid), 32'd0);
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (issue_log.size() < n && k < 200) begin tick(); k++; end
        chk(name, 32'(issue_log.size() >= n), 32'd1);
    endtask

    task automatic wait_acc(input int n, input string name);
        int k = 0;
        int s = n_acc;
        while (n_acc < s + n && k < 300) begin tick(); k++; end
        chk(name, 32'(n_acc >= s + n), 32'd1);
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (issue_log.size() > i) ? issue_log[i] : 32'hDEAD_BEEF;
    endfunction

    logic [31:0] cap_instr, cap_pc;
    bit          found;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1; restart(32'h0);

        // 1: streaming from RESET_PC with 1-cycle latency.
        run(30);
        chk("t1_addr0", log_at(0), 32'h0);
        chk("t1_addr1", log_at(1), 32'h4);
        chk("t1_addr2", log_at(2), 32'h8);
        chk("t1_progress", 32'(n_acc >= 10), 32'd1);

        // 2: decode stall holds data and throttles requests.
        rdy_pct = 0;
        run(4);
        chk("t2_valid", 32'(if_valid), 32'd1);
        cap_instr = if_instr; cap_pc = if_pc;
        run(8);
        chk("t2_hold_instr", if_instr, cap_instr);
        chk("t2_hold_pc", if_pc, cap_pc);
        chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        rdy_pct = 100;
        run(20);

        // 3: redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        redirect(32'h10);
        wait_log(2, "t3_two_issued");
        chk("t3_inflight", 32'(pend.size()), 32'd2);
        redirect(32'h103);
        wait_log(1, "t3_new_issue");
        chk("t3_first_addr", log_at(0), 32'h100);
        wait_acc(3, "t3_resume");

        // 4: redirect coinciding with a response and a decode pop.
        lat_min = 1; lat_max = 3;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if_ready = 1'b1;
            if (imem_rsp_valid && if_valid) begin
                found = 1;
                redirect(32'h400);
            end
        end
        chk("t4_collision_seen", 32'(found), 32'd1);
        wait_acc(3, "t4_resume");

        // 5: back-to-back redirects with 3-cycle latency.
        lat_min = 3; lat_max = 3;
        redirect(32'h200);
        tick();
        redirect(32'h300);
        wait_acc(4, "t5_resume");

        // Random traffic with random redirects.
        lat_min = 1; lat_max = 4; req_pct = 70; rdy_pct = 60;
        for (int k = 0; k < 300; k++) begin
            tick();
            if ($urandom_range(19) == 0) redirect($urandom());
        end

        // 6: PC wrap, then asynchronous reset mid-stream.
        lat_min = 1; lat_max = 1; req_pct = 100; rdy_pct = 100;
        redirect(32'hFFFF_FFF8);
        wait_log(3, "t6_wrap_issued");
        chk("t6_addr_fc", log_at(1), 32'hFFFF_FFFC);
        chk("t6_addr_wrap", log_at(2), 32'h0);
        wait_acc(4, "t6_wrap_accepted");
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (if_valid) found = 1;
        end
        chk("t6_busy_before_rst", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_if_valid", 32'(if_valid), 32'd0);
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_if_pc", if_pc, 32'd0);
        tick(); tick();
        rst_n = 1'b1; restart(32'h0);
        wait_log(2, "t6_restart_issued");
        chk("t6_restart_addr", log_at(0), 32'h0);
        wait_acc(3, "t6_restart_accepted");

        chk("overall_progress", 32'(n_acc >= 60), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
